// File: rtl/spi_display_rx.sv
// SPI display receiver: decodes an SSD1331-style 4-wire SPI command/pixel stream
// into pixel write strobes with (x, y, RGB332) and a display-on flag.
// Optional column mirror (A0 param bit 1) enabled by SPI_DISPLAY_RX_REMAP_EN.
module spi_display_rx #(
  parameter int unsigned COLS = 96,
  parameter int unsigned ROWS = 64
) (
  input  logic       clk,
  input  logic       resn,
  input  logic       oled_csn,
  input  logic       oled_clk,
  input  logic       oled_mosi,
  input  logic       oled_dc,
  input  logic       oled_resn,
  output logic       px_we,
  output logic [6:0] px_x,
  output logic [5:0] px_y,
  output logic [7:0] px_data,
  output logic       disp_on
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StParam1 = 2'd1;
  localparam logic [1:0] StParam2 = 2'd2;

  localparam logic [6:0] XMax = 7'(COLS - 1);
  localparam logic [5:0] YMax = 6'(ROWS - 1);

  // Synchronizer chains, [1] is the synchronized value
  logic [1:0] csn_sq, sclk_sq, mosi_sq, dc_sq, rstn_sq;
  logic       sclk_prev_q;
  logic       csn_s, mosi_s, dc_s, soft_rst, sclk_rise;

  // Byte assembly
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       byte_vld_q;
  logic [7:0] byte_q;
  logic       byte_dc_q;

  // Parser and pixel address state
  logic [1:0] state_q, state_d;
  logic [7:0] opcode_q, opcode_d;
  logic [6:0] p1_q, p1_d;
  logic [6:0] col_start_q, col_start_d, col_end_q, col_end_d;
  logic [5:0] row_start_q, row_start_d, row_end_q, row_end_d;
  logic [6:0] x_q, x_d;
  logic [5:0] y_q, y_d;
  logic       disp_on_q, disp_on_d;
  logic       px_we_q, px_we_d;
  logic [6:0] px_x_q, px_x_d;
  logic [5:0] px_y_q, px_y_d;
  logic [7:0] px_data_q, px_data_d;
`ifdef SPI_DISPLAY_RX_REMAP_EN
  logic [7:0] a0_q, a0_d;
`endif

  logic       one_param;
  logic [6:0] clamp_x, end_x, x_out;
  logic [5:0] clamp_y, end_y;

  assign csn_s     = csn_sq[1];
  assign mosi_s    = mosi_sq[1];
  assign dc_s      = dc_sq[1];
  assign soft_rst  = ~rstn_sq[1];
  assign sclk_rise = sclk_sq[1] & ~sclk_prev_q;

  // Two-flop synchronizers plus SCLK history for edge detection
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      csn_sq      <= 2'b11;
      sclk_sq     <= 2'b11;
      mosi_sq     <= 2'b00;
      dc_sq       <= 2'b00;
      rstn_sq     <= 2'b00;
      sclk_prev_q <= 1'b1;
    end else begin
      csn_sq      <= {csn_sq[0], oled_csn};
      sclk_sq     <= {sclk_sq[0], oled_clk};
      mosi_sq     <= {mosi_sq[0], oled_mosi};
      dc_sq       <= {dc_sq[0], oled_dc};
      rstn_sq     <= {rstn_sq[0], oled_resn};
      sclk_prev_q <= sclk_sq[1];
    end
  end

  // MSB-first shifter; a completed byte is presented for one cycle with its dc bit
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      byte_vld_q <= 1'b0;
      byte_q     <= 8'd0;
      byte_dc_q  <= 1'b0;
    end else if (soft_rst) begin
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      byte_vld_q <= 1'b0;
      byte_q     <= 8'd0;
      byte_dc_q  <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      if (csn_s) begin
        bit_cnt_q <= 3'd0;
      end else if (sclk_rise) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_vld_q <= 1'b1;
          byte_q     <= {shift_q, mosi_s};
          byte_dc_q  <= dc_s;
        end
      end
    end
  end

  // Opcodes that consume exactly one parameter byte
  always_comb begin
    one_param = 1'b0;
    case (byte_q)
      8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB1, 8'hF0, 8'h8A,
      8'h8B, 8'h8C, 8'hBB, 8'h81, 8'h82, 8'h83, 8'hBE, 8'h87: one_param = 1'b1;
      default: one_param = 1'b0;
    endcase
  end

  assign clamp_x = (byte_q > {1'b0, XMax}) ? XMax : byte_q[6:0];
  assign clamp_y = (byte_q > {2'b00, YMax}) ? YMax : byte_q[5:0];
  assign end_x   = (clamp_x < p1_q) ? p1_q : clamp_x;
  assign end_y   = (clamp_y < p1_q[5:0]) ? p1_q[5:0] : clamp_y;

`ifdef SPI_DISPLAY_RX_REMAP_EN
  assign x_out = a0_q[1] ? (XMax - x_q) : x_q;
`else
  assign x_out = x_q;
`endif

  // Command parser and pixel address generator next-state
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    p1_d        = p1_q;
    col_start_d = col_start_q;
    col_end_d   = col_end_q;
    row_start_d = row_start_q;
    row_end_d   = row_end_q;
    x_d         = x_q;
    y_d         = y_q;
    disp_on_d   = disp_on_q;
    px_we_d     = 1'b0;
    px_x_d      = px_x_q;
    px_y_d      = px_y_q;
    px_data_d   = px_data_q;
`ifdef SPI_DISPLAY_RX_REMAP_EN
    a0_d        = a0_q;
`endif
    if (byte_vld_q) begin
      if (byte_dc_q) begin
        // Pixel data always wins; any half-received command is dropped
        state_d   = StIdle;
        px_we_d   = 1'b1;
        px_data_d = byte_q;
        px_x_d    = x_out;
        px_y_d    = y_q;
        if (x_q >= col_end_q) begin
          x_d = col_start_q;
          y_d = (y_q >= row_end_q) ? row_start_q : y_q + 6'd1;
        end else begin
          x_d = x_q + 7'd1;
        end
      end else begin
        case (state_q)
          StIdle: begin
            opcode_d = byte_q;
            if (byte_q == 8'hAE) disp_on_d = 1'b0;
            if (byte_q == 8'hAF) disp_on_d = 1'b1;
            if (byte_q == 8'h15 || byte_q == 8'h75 || one_param) state_d = StParam1;
          end
          StParam1: begin
            if (opcode_q == 8'h15) begin
              p1_d    = clamp_x;
              state_d = StParam2;
            end else if (opcode_q == 8'h75) begin
              p1_d    = {1'b0, clamp_y};
              state_d = StParam2;
            end else begin
`ifdef SPI_DISPLAY_RX_REMAP_EN
              if (opcode_q == 8'hA0) a0_d = byte_q;
`endif
              state_d = StIdle;
            end
          end
          StParam2: begin
            if (opcode_q == 8'h15) begin
              col_start_d = p1_q;
              col_end_d   = end_x;
              x_d         = p1_q;
            end else begin
              row_start_d = p1_q[5:0];
              row_end_d   = end_y;
              y_d         = p1_q[5:0];
            end
            state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // Parser state registers; oled_resn acts as a synchronous clear
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q     <= StIdle;
      opcode_q    <= 8'd0;
      p1_q        <= 7'd0;
      col_start_q <= 7'd0;
      col_end_q   <= XMax;
      row_start_q <= 6'd0;
      row_end_q   <= YMax;
      x_q         <= 7'd0;
      y_q         <= 6'd0;
      disp_on_q   <= 1'b0;
      px_we_q     <= 1'b0;
      px_x_q      <= 7'd0;
      px_y_q      <= 6'd0;
      px_data_q   <= 8'd0;
`ifdef SPI_DISPLAY_RX_REMAP_EN
      a0_q        <= 8'd0;
`endif
    end else if (soft_rst) begin
      state_q     <= StIdle;
      opcode_q    <= 8'd0;
      p1_q        <= 7'd0;
      col_start_q <= 7'd0;
      col_end_q   <= XMax;
      row_start_q <= 6'd0;
      row_end_q   <= YMax;
      x_q         <= 7'd0;
      y_q         <= 6'd0;
      disp_on_q   <= 1'b0;
      px_we_q     <= 1'b0;
      px_x_q      <= 7'd0;
      px_y_q      <= 6'd0;
      px_data_q   <= 8'd0;
`ifdef SPI_DISPLAY_RX_REMAP_EN
      a0_q        <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      p1_q        <= p1_d;
      col_start_q <= col_start_d;
      col_end_q   <= col_end_d;
      row_start_q <= row_start_d;
      row_end_q   <= row_end_d;
      x_q         <= x_d;
      y_q         <= y_d;
      disp_on_q   <= disp_on_d;
      px_we_q     <= px_we_d;
      px_x_q      <= px_x_d;
      px_y_q      <= px_y_d;
      px_data_q   <= px_data_d;
`ifdef SPI_DISPLAY_RX_REMAP_EN
      a0_q        <= a0_d;
`endif
    end
  end

  assign px_we   = px_we_q;
  assign px_x    = px_x_q;
  assign px_y    = px_y_q;
  assign px_data = px_data_q;
  assign disp_on = disp_on_q;

endmodule
